// File: rtl/out_display_if.sv
// Bundle between the output-register source and the 7-segment display driver.
// The source drives the value, and the display returns the segment, anode and busy lines.
interface out_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) ();
    logic [WIDTH-1:0]  i_data;
    logic              i_signed;
    logic [6:0]        o_seg;
    logic [DIGITS-1:0] o_anode;
    logic              o_busy;

    modport master (output i_data, output i_signed,
                    input  o_seg, input o_anode, input o_busy);
    modport slave  (input  i_data, input i_signed,
                    output o_seg, output o_anode, output o_busy);
endinterface

// File: rtl/out_display.sv
// Drives a multiplexed common-anode 7-segment display showing the output register.
// A change in the value starts a double-dabble BCD conversion. A continuous scan shows the last converted value.
module out_display #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 16
) (
    input  logic          mclk,
    input  logic          i_rst,
    out_display_if.slave  bus
);
    // state | meaning
    // IDLE  | waiting for {i_signed,i_data} to differ from the last captured pair
    // SHIFT | one double-dabble step per cycle, WIDTH cycles
    // LOAD  | copy the BCD result and sign into the display registers

    localparam int ND = DIGITS - 1;
    localparam int BW = 4 * ND;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t              state, state_next;
    logic [WIDTH-1:0]    last_value;
    logic                last_signed;
    logic [BW+WIDTH-1:0] sr, sr_adj;
    logic [CW-1:0]       bit_cnt;
    logic                neg;
    logic [BW-1:0]       disp_bcd;
    logic                disp_neg;
    logic [RW-1:0]       refresh_cnt;
    logic [IW-1:0]       digit_idx, digit_next;
    logic [6:0]          seg_r, seg_next;
    logic [DIGITS-1:0]   anode_r;
    logic [WIDTH-1:0]    mag;
    logic                in_neg, changed, busy, cap, load;
    logic [ND-1:0]       shown;
    logic [3:0]          nib;
    logic                show;
    logic                nz;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        in_neg  = bus.i_signed & bus.i_data[WIDTH-1];
        mag     = in_neg ? (~bus.i_data + WIDTH'(1)) : bus.i_data;
        changed = {bus.i_signed, bus.i_data} != {last_signed, last_value};
    end

    always_ff @(posedge mclk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        cap        = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (changed) begin
                    cap        = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (bit_cnt == CW'(WIDTH - 1)) state_next = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                load       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sr_adj = sr;
        for (int k = 0; k < ND; k++) begin
            if (sr[WIDTH+4*k +: 4] >= 4'd5)
                sr_adj[WIDTH+4*k +: 4] = sr[WIDTH+4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge mclk or posedge i_rst) begin
        if (i_rst) begin
            last_value  <= '0;
            last_signed <= 1'b0;
            sr          <= '0;
            bit_cnt     <= '0;
            neg         <= 1'b0;
            disp_bcd    <= '0;
            disp_neg    <= 1'b0;
        end else begin
            if (cap) begin
                last_value  <= bus.i_data;
                last_signed <= bus.i_signed;
                neg         <= in_neg;
                sr          <= {{BW{1'b0}}, mag};
                bit_cnt     <= '0;
            end else if (state == SHIFT) begin
                sr      <= sr_adj << 1;
                bit_cnt <= bit_cnt + CW'(1);
            end
            // The display registers change only here, so the scan never sees a partial result.
            if (load) begin
                disp_bcd <= sr[BW+WIDTH-1:WIDTH];
                disp_neg <= neg;
            end
        end
    end

    always_comb begin
        digit_next = digit_idx;
        if (refresh_cnt == RW'(REFRESH_DIV - 1))
            digit_next = (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + IW'(1);
    end

    // Leading-zero blanking: a digit is shown once it or any higher digit is nonzero.
    always_comb begin
        shown = '0;
        nz    = 1'b0;
        for (int k = ND - 1; k >= 0; k--) begin
            nz       = nz | (disp_bcd[4*k +: 4] != 4'd0);
            shown[k] = nz;
        end
    end

    always_comb begin
        nib  = 4'd0;
        show = 1'b0;
        for (int k = 0; k < ND; k++) begin
            if (digit_next == IW'(k)) begin
                nib  = disp_bcd[4*k +: 4];
                show = (k == 0) || shown[k];
            end
        end
        if (digit_next == IW'(DIGITS - 1))
            seg_next = disp_neg ? 7'b0111111 : 7'b1111111;
        else
            seg_next = show ? seg_decode(nib) : 7'b1111111;
    end

    always_ff @(posedge mclk or posedge i_rst) begin
        if (i_rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            anode_r     <= ~DIGITS'(1);
            seg_r       <= 7'b1000000;
        end else begin
            refresh_cnt <= (refresh_cnt == RW'(REFRESH_DIV - 1)) ? '0 : refresh_cnt + RW'(1);
            digit_idx   <= digit_next;
            anode_r     <= ~(DIGITS'(1) << digit_next);
            seg_r       <= seg_next;
        end
    end

    assign bus.o_seg   = seg_r;
    assign bus.o_anode = anode_r;
    assign bus.o_busy  = busy;
endmodule
